// File: rtl/ann_mac_sequencer.sv
// Sequencer for the hidden-layer MAC bank: streams one window of pixels and weight rows
// into the lanes, waits out the MAC pipeline, captures the lane sums and hands them off.
module ann_mac_sequencer #(
  parameter int N_LANES  = 20,
  parameter int N_INPUTS = 400,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int MAC_LAT  = 1
) (
  input  logic                        iClk,
  input  logic                        iReset,
  input  logic                        iStart,
  input  logic [N_LANES-1:0]          iLane_mask,
  output logic                        oRd_en,
  output logic [ADDR_W-1:0]           oRd_addr,
  input  logic [DATA_W-1:0]           iRd_data,
  input  logic [N_LANES*DATA_W-1:0]   iRd_weights,
  output logic [N_LANES-1:0]          oInput_ready,
  output logic [DATA_W-1:0]           oData,
  output logic [N_LANES*DATA_W-1:0]   oWeights,
  output logic                        oFinish,
  input  logic [N_LANES*DATA_W-1:0]   iMac_out,
  output logic [N_LANES*DATA_W-1:0]   oResult,
  output logic                        oResult_valid,
  input  logic                        iResult_ready,
  output logic                        oBusy
);

  localparam int CNT_W = $clog2(MAC_LAT + 1) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_INPUTS - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(MAC_LAT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DRAIN   = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [N_LANES-1:0]          mask_q, mask_d;
  logic                        rd_en_q, rd_en_d;
  logic                        rd_en_dly_q;
  logic [N_LANES-1:0]          ready_q;
  logic [DATA_W-1:0]           data_q;
  logic [N_LANES*DATA_W-1:0]   weights_q;
  logic                        finish_q, finish_d;
  logic                        valid_q, valid_d;
  logic [N_LANES*DATA_W-1:0]   result_q, result_d;
  logic                        busy_q, busy_d;

  // State and control registers
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      rd_en_q  <= 1'b0;
      finish_q <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      rd_en_q  <= rd_en_d;
      finish_q <= finish_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (iStart) state_d = S_FETCH; else state_d = S_IDLE;
      S_FETCH:   if (addr_q == LAST_ADDR) state_d = S_DRAIN; else state_d = S_FETCH;
      S_DRAIN:   if (cnt_q == DRAIN_LAST) state_d = S_CAPTURE; else state_d = S_DRAIN;
      S_CAPTURE: state_d = S_HOLD;
      S_HOLD:    if (valid_q && iResult_ready) state_d = S_IDLE; else state_d = S_HOLD;
      default:   state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and counters
  always_comb begin
    rd_en_d  = (state_d == S_FETCH);
    busy_d   = (state_d != S_IDLE);
    addr_d   = addr_q;
    cnt_d    = '0;
    mask_d   = mask_q;
    finish_d = 1'b0;
    valid_d  = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (iStart) mask_d = iLane_mask; else mask_d = mask_q;
      end
      S_FETCH: begin
        // The address saturates on the last element instead of wrapping.
        if (addr_q != LAST_ADDR) addr_d = addr_q + ADDR_W'(1); else addr_d = addr_q;
      end
      S_DRAIN: cnt_d = cnt_q + CNT_W'(1);
      S_CAPTURE: begin
        result_d = iMac_out;
        valid_d  = 1'b1;
        finish_d = 1'b1;
      end
      S_HOLD:  valid_d = valid_q & ~iResult_ready;
      default: valid_d = 1'b0;
    endcase
  end

  // Lane feed stage: loads the word returned one cycle after each read strobe
  always_ff @(posedge iClk) begin
    if (iReset) begin
      rd_en_dly_q <= 1'b0;
      ready_q     <= '0;
      data_q      <= '0;
      weights_q   <= '0;
    end else begin
      rd_en_dly_q <= rd_en_q;
      if (rd_en_dly_q) begin
        data_q    <= iRd_data;
        weights_q <= iRd_weights;
        ready_q   <= mask_q;
      end else begin
        ready_q   <= '0;
      end
    end
  end

  assign oRd_en        = rd_en_q;
  assign oRd_addr      = addr_q;
  assign oInput_ready  = ready_q;
  assign oData         = data_q;
  assign oWeights      = weights_q;
  assign oFinish       = finish_q;
  assign oResult       = result_q;
  assign oResult_valid = valid_q;
  assign oBusy         = busy_q;

endmodule
